// File: rtl/mem_ctrl_gen_if.sv
// mem_ctrl_gen_if: groups the 8-bit memory port and the fetch/load/store
// request channels of mem_ctrl_gen.
// slave  = controller side, master = requester/memory side.
interface mem_ctrl_gen_if #(
   parameter int ADDR_W = 32
);
   logic [7:0]        mem_din;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_dout;
   logic              mem_wr;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [31:0]       if_rdata;
   logic              ld_req;
   logic [1:0]        ld_size;
   logic              ld_unsigned;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_ack;
   logic [31:0]       ld_rdata;
   logic              st_req;
   logic [1:0]        st_size;
   logic [ADDR_W-1:0] st_addr;
   logic [31:0]       st_wdata;
   logic              st_ack;
   logic              busy;

   modport slave (
      input  mem_din, if_req, if_addr, ld_req, ld_size, ld_unsigned, ld_addr,
             st_req, st_size, st_addr, st_wdata,
      output mem_addr, mem_dout, mem_wr, if_ack, if_rdata, ld_ack, ld_rdata,
             st_ack, busy
   );

   modport master (
      output mem_din, if_req, if_addr, ld_req, ld_size, ld_unsigned, ld_addr,
             st_req, st_size, st_addr, st_wdata,
      input  mem_addr, mem_dout, mem_wr, if_ack, if_rdata, ld_ack, ld_rdata,
             st_ack, busy
   );
endinterface

// File: rtl/mem_ctrl_gen.sv
// mem_ctrl_gen: byte-serial memory controller arbitrating fetch, load and
// store channels onto one 8-bit synchronous memory port (little-endian).
// Reads overlap address issue with data capture through a MEM_LAT-deep
// capture pipeline. Optional one-entry fetch buffer: MEM_CTRL_FETCH_BUF_EN.
module mem_ctrl_gen #(
   parameter int ADDR_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int FETCH_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   mem_ctrl_gen_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2, ST_DONE = 2'd3} state_t;
   typedef enum logic [1:0] {CH_IF = 2'd0, CH_LD = 2'd1, CH_ST = 2'd2} chan_t;

   state_t              r_state;
   chan_t               r_chan;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [31:0]         r_wdata;
   logic [2:0]          r_n;
   logic [2:0]          r_k;
   logic [1:0]          r_cap_k;
   logic [31:0]         r_data;
   logic [MEM_LAT-1:0]  r_pipe;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [7:0]          r_mem_dout;
   logic                r_mem_wr;
   logic                r_if_ack;
   logic [31:0]         r_if_rdata;
   logic                r_ld_ack;
   logic [31:0]         r_ld_rdata;
   logic                r_st_ack;
   logic                r_busy;

   logic                w_gnt_if;
   logic                w_gnt_ld;
   logic                w_gnt_st;
   logic                w_issue;
   logic [2:0]          w_k_nxt;
   logic [31:0]         w_word;

`ifdef MEM_CTRL_FETCH_BUF_EN
   logic                r_fb_v;
   logic [ADDR_W-1:0]   r_fb_tag;
   logic [31:0]         r_fb_word;
   logic                r_hit;
   logic                w_hit;

   assign w_hit = r_fb_v && (bus.if_addr == r_fb_tag);
`endif

   // Number of bytes moved for a given access size.
   function automatic logic [2:0] size_to_n(input logic [1:0] size);
      case (size)
         2'd0:    size_to_n = 3'd1;
         2'd1:    size_to_n = 3'd2;
         default: size_to_n = 3'd4;
      endcase
   endfunction

   // Sign/zero extension of the assembled load word.
   function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                          input logic uns);
      case (size)
         2'd0:    extend = {{24{~uns & word[7]}}, word[7:0]};
         2'd1:    extend = {{16{~uns & word[15]}}, word[15:0]};
         default: extend = word;
      endcase
   endfunction

   assign w_issue = (r_state == ST_RD) && (r_k < r_n);
   assign w_k_nxt = r_k + 3'd1;

   // Fixed-priority grant; a channel whose ack is high is never granted.
   always_comb begin
      w_gnt_if = 1'b0;
      w_gnt_ld = 1'b0;
      w_gnt_st = 1'b0;
      if (FETCH_PRIO == 1) begin
         if (bus.if_req && !r_if_ack)      w_gnt_if = 1'b1;
         else if (bus.st_req && !r_st_ack) w_gnt_st = 1'b1;
         else if (bus.ld_req && !r_ld_ack) w_gnt_ld = 1'b1;
         else                              w_gnt_if = 1'b0;
      end else begin
         if (bus.st_req && !r_st_ack)      w_gnt_st = 1'b1;
         else if (bus.ld_req && !r_ld_ack) w_gnt_ld = 1'b1;
         else if (bus.if_req && !r_if_ack) w_gnt_if = 1'b1;
         else                              w_gnt_st = 1'b0;
      end
   end

   // Read word with the byte arriving this cycle merged into its lane.
   always_comb begin
      w_word = r_data;
      w_word[{r_cap_k, 3'b000} +: 8] = bus.mem_din;
   end

   // Controller FSM: arbitration, byte sequencing, capture and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_chan     <= CH_IF;
         r_addr     <= {ADDR_W{1'b0}};
         r_size     <= 2'd0;
         r_uns      <= 1'b0;
         r_wdata    <= 32'd0;
         r_n        <= 3'd0;
         r_k        <= 3'd0;
         r_cap_k    <= 2'd0;
         r_data     <= 32'd0;
         r_pipe     <= {MEM_LAT{1'b0}};
         r_mem_addr <= {ADDR_W{1'b0}};
         r_mem_dout <= 8'd0;
         r_mem_wr   <= 1'b0;
         r_if_ack   <= 1'b0;
         r_if_rdata <= 32'd0;
         r_ld_ack   <= 1'b0;
         r_ld_rdata <= 32'd0;
         r_st_ack   <= 1'b0;
         r_busy     <= 1'b0;
`ifdef MEM_CTRL_FETCH_BUF_EN
         r_fb_v     <= 1'b0;
         r_fb_tag   <= {ADDR_W{1'b0}};
         r_fb_word  <= 32'd0;
         r_hit      <= 1'b0;
`endif
      end else begin
         r_if_ack <= 1'b0;
         r_ld_ack <= 1'b0;
         r_st_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_mem_wr   <= 1'b0;
               r_mem_addr <= {ADDR_W{1'b0}};
               r_mem_dout <= 8'd0;
               r_busy     <= 1'b0;
               r_k        <= 3'd0;
               r_cap_k    <= 2'd0;
               r_data     <= 32'd0;
               r_pipe     <= {MEM_LAT{1'b0}};
               if (w_gnt_st) begin
                  r_chan     <= CH_ST;
                  r_addr     <= bus.st_addr;
                  r_size     <= bus.st_size;
                  r_wdata    <= bus.st_wdata;
                  r_n        <= size_to_n(bus.st_size);
                  r_mem_wr   <= 1'b1;
                  r_mem_addr <= bus.st_addr;
                  r_mem_dout <= bus.st_wdata[7:0];
                  r_busy     <= 1'b1;
                  r_state    <= ST_WR;
`ifdef MEM_CTRL_FETCH_BUF_EN
                  r_fb_v     <= 1'b0;
`endif
               end else if (w_gnt_ld) begin
                  r_chan     <= CH_LD;
                  r_addr     <= bus.ld_addr;
                  r_size     <= bus.ld_size;
                  r_uns      <= bus.ld_unsigned;
                  r_n        <= size_to_n(bus.ld_size);
                  r_mem_addr <= bus.ld_addr;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RD;
               end else if (w_gnt_if) begin
                  r_chan     <= CH_IF;
                  r_addr     <= bus.if_addr;
                  r_size     <= 2'd2;
                  r_uns      <= 1'b0;
                  r_n        <= 3'd4;
`ifdef MEM_CTRL_FETCH_BUF_EN
                  if (w_hit) begin
                     r_hit      <= 1'b1;
                     r_state    <= ST_DONE;
                  end else begin
                     r_mem_addr <= bus.if_addr;
                     r_busy     <= 1'b1;
                     r_state    <= ST_RD;
                  end
`else
                  r_mem_addr <= bus.if_addr;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RD;
`endif
               end
            end
            ST_RD: begin
               if (w_issue) begin
                  r_k <= w_k_nxt;
                  if (w_k_nxt < r_n) r_mem_addr <= r_addr + ADDR_W'(w_k_nxt);
                  else               r_mem_addr <= {ADDR_W{1'b0}};
               end
               r_pipe <= (r_pipe << 1) | MEM_LAT'(w_issue);
               if (r_pipe[MEM_LAT-1]) begin
                  r_data  <= w_word;
                  r_cap_k <= r_cap_k + 2'd1;
                  if (r_cap_k == (r_n[1:0] - 2'd1)) begin
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                     if (r_chan == CH_IF) begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= w_word;
`ifdef MEM_CTRL_FETCH_BUF_EN
                        r_fb_v     <= 1'b1;
                        r_fb_tag   <= r_addr;
                        r_fb_word  <= w_word;
`endif
                     end else begin
                        r_ld_ack   <= 1'b1;
                        r_ld_rdata <= extend(w_word, r_size, r_uns);
                     end
                  end
               end
            end
            ST_WR: begin
               if (w_k_nxt < r_n) begin
                  r_k        <= w_k_nxt;
                  r_mem_addr <= r_addr + ADDR_W'(w_k_nxt);
                  r_mem_dout <= r_wdata[{w_k_nxt[1:0], 3'b000} +: 8];
               end else begin
                  r_mem_wr   <= 1'b0;
                  r_mem_addr <= {ADDR_W{1'b0}};
                  r_mem_dout <= 8'd0;
                  r_st_ack   <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
`ifdef MEM_CTRL_FETCH_BUF_EN
               // A buffer hit spends one cycle here silently, then acks from the buffer.
               if (r_hit) begin
                  r_hit      <= 1'b0;
                  r_if_ack   <= 1'b1;
                  r_if_rdata <= r_fb_word;
               end else begin
                  r_state    <= ST_IDLE;
               end
`else
               r_state <= ST_IDLE;
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_dout = r_mem_dout;
   assign bus.mem_wr   = r_mem_wr;
   assign bus.if_ack   = r_if_ack;
   assign bus.if_rdata = r_if_rdata;
   assign bus.ld_ack   = r_ld_ack;
   assign bus.ld_rdata = r_ld_rdata;
   assign bus.st_ack   = r_st_ack;
   assign bus.busy     = r_busy;
endmodule
